// File: rtl/debounce_fsm_pkg.sv
// Shared definitions for the push-button debouncers: FSM state encodings
// and a helper deciding which states present a high debounced level.
package debounce_fsm_pkg;

    typedef enum logic [1:0] {
        StZero  = 2'd0,
        StWait1 = 2'd1,
        StOne   = 2'd2,
        StWait0 = 2'd3
    } state_e;

    // The level only flips once a change is accepted, so WAIT0 still reads high.
    function automatic logic is_high_level(state_e st);
        return (st == StOne) || (st == StWait0);
    endfunction

endpackage

// File: rtl/debounce_fsm_if.sv
// Signal bundle between the tick/button side and the debouncer outputs.
interface debounce_fsm_if;

    logic tick;
    logic sw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    modport master (
        output tick,
        output sw_in,
        input  db_level,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  tick,
        input  sw_in,
        output db_level,
        output db_rise,
        output db_fall
    );

endinterface

// File: rtl/debounce_fsm_sync_ff.sv
// Multi-flop synchronizer for a raw asynchronous input; clears to 0 on reset.
module debounce_fsm_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage further along the chain each clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Chain registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Button debouncer: accepts a level change only after the synchronized input
// has held steady across STABLE_TICKS counted sample ticks, and emits
// registered level plus one-cycle rise/fall pulses.
module debounce_fsm
    import debounce_fsm_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           reset,
    debounce_fsm_if.slave  bus
);

    localparam int unsigned      CntW    = $clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_TICKS - 1);
    localparam logic [CntW-1:0]  CntMax  = CntW'(STABLE_TICKS);

    logic            sw_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    debounce_fsm_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.sw_in),
        .q_o   (sw_s)
    );

    // Next state, stability count and output values. A revert beats a tick in
    // the same cycle, and the entry cycle into a WAIT state never counts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StZero: begin
                if (sw_s) begin
                    state_d = StWait1;
                    cnt_d   = '0;
                end
            end
            StWait1: begin
                if (!sw_s) begin
                    state_d = StZero;
                    cnt_d   = '0;
                end else if (bus.tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = StOne;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StOne: begin
                if (!sw_s) begin
                    state_d = StWait0;
                    cnt_d   = '0;
                end
            end
            StWait0: begin
                if (sw_s) begin
                    state_d = StOne;
                    cnt_d   = '0;
                end else if (bus.tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = StZero;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
        endcase
        level_d = is_high_level(state_d);
    end

    // FSM, counter and registered outputs; reset drops any pending change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StZero;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.db_level = level_q;
    assign bus.db_rise  = rise_q;
    assign bus.db_fall  = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm (STABLE_TICKS=3, SYNC_STAGES=2, tick every 10 clk).
module tb_debounce_fsm;
    import debounce_fsm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    debounce_fsm_if bus ();

    debounce_fsm #(
        .STABLE_TICKS (3),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } exp_t;

    typedef struct {
        logic sw;
        int   tog;
        int   cycles;
        int   rises;
        int   falls;
        logic lvl;
    } row_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   last_rise_cyc = -1;

    // Reference model: accepted level plus count of ticks seen while the
    // synchronized input disagrees with it.
    logic h1 = 1'b0, h2 = 1'b0, m_lvl = 1'b0, m_wait = 1'b0;
    int   m_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic timeout_chk(input string name, input int n, input int limit);
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: bound of %0d cycles expired", name, limit);
        end
    endtask

    // One clock cycle: drive inputs, predict next-cycle outputs, check this cycle.
    task automatic step(input logic sw, input logic rst);
        logic s;
        exp_t e;
        exp_t got;
        bus.sw_in = sw;
        bus.tick  = (cyc % 10 == 9);
        reset     = rst;
        e = '0;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            h1 = 1'b0; h2 = 1'b0; m_lvl = 1'b0; m_wait = 1'b0; m_pend = 0;
        end else begin
            s = h2;
            if (s == m_lvl) begin
                m_wait = 1'b0;
                m_pend = 0;
            end else if (!m_wait) begin
                m_wait = 1'b1;
                m_pend = 0;
            end else if (bus.tick) begin
                m_pend++;
                if (m_pend == 3) begin
                    m_lvl  = s;
                    e.rise = s;
                    e.fall = ~s;
                    m_wait = 1'b0;
                    m_pend = 0;
                end
            end
            e.lvl = m_lvl;
            h2 = h1;
            h1 = sw;
        end
        exp_q.push_back(e);
        @(negedge clk);
        got = {bus.db_level, bus.db_rise, bus.db_fall};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty@%0d", cyc);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("db_level@%0d", cyc), 32'(got.lvl), 32'(e.lvl));
            chk($sformatf("db_rise@%0d", cyc), 32'(got.rise), 32'(e.rise));
            chk($sformatf("db_fall@%0d", cyc), 32'(got.fall), 32'(e.fall));
        end
        chk($sformatf("rise_fall_overlap@%0d", cyc), 32'(got.rise & got.fall), 32'd0);
        if (got.rise === 1'b1) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (got.fall === 1'b1) fall_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_two_ticks(input string name);
        int n;
        n = 0;
        while (!(m_wait && m_pend == 2) && n < 100) begin
            step(1'b1, 1'b0);
            n++;
        end
        timeout_chk(name, n, 100);
    endtask

    initial begin
        row_t rows[7];
        int   g;
        int   r;
        int   c;

        bus.sw_in = 1'b1;
        bus.tick  = 1'b0;

        // Reset held 5 clk with the raw input high.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        chk("reset_state", 32'(dut.state_q), 32'(StZero));
        chk("reset_level", 32'(bus.db_level), 32'd0);
        step(1'b0, 1'b0);
        chk("state_after_release", 32'(dut.state_q), 32'(StZero));

        rows[0] = '{sw: 1'b0, tog: 0, cycles: 20, rises: 0, falls: 0, lvl: 1'b0};
        rows[1] = '{sw: 1'b1, tog: 0, cycles: 60, rises: 1, falls: 0, lvl: 1'b1};
        rows[2] = '{sw: 1'b0, tog: 0, cycles: 60, rises: 0, falls: 1, lvl: 1'b0};
        rows[3] = '{sw: 1'b1, tog: 3, cycles: 50, rises: 0, falls: 0, lvl: 1'b0};
        rows[4] = '{sw: 1'b0, tog: 0, cycles: 30, rises: 0, falls: 0, lvl: 1'b0};
        rows[5] = '{sw: 1'b1, tog: 0, cycles: 60, rises: 1, falls: 0, lvl: 1'b1};
        rows[6] = '{sw: 1'b0, tog: 0, cycles: 60, rises: 0, falls: 1, lvl: 1'b0};

        for (int k = 0; k < 7; k++) begin
            rise_cnt = 0;
            fall_cnt = 0;
            for (int i = 0; i < rows[k].cycles; i++) begin
                if (rows[k].tog != 0 && ((i / rows[k].tog) % 2 == 1)) step(~rows[k].sw, 1'b0);
                else step(rows[k].sw, 1'b0);
            end
            chk($sformatf("row%0d_rises", k), 32'(rise_cnt), 32'(rows[k].rises));
            chk($sformatf("row%0d_falls", k), 32'(fall_cnt), 32'(rows[k].falls));
            chk($sformatf("row%0d_level", k), 32'(bus.db_level), 32'(rows[k].lvl));
        end

        // Revert coinciding with the would-be third tick sends WAIT1 back to ZERO.
        run_to_two_ticks("t5_reach_wait1");
        chk("t5_in_wait1", 32'(dut.state_q), 32'(StWait1));
        chk("t5_cnt_two", 32'(dut.cnt_q), 32'd2);
        while (cyc % 10 != 7) step(1'b1, 1'b0);
        g = cyc;
        rise_cnt = 0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t5_back_to_zero", 32'(dut.state_q), 32'(StZero));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk("t5_rise_count", 32'(rise_cnt), 32'd1);
        chk("t5_rise_cycle", 32'(last_rise_cyc), 32'(g + 33));

        // Reset in WAIT1 after two ticks aborts the pending rise.
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
        chk("t6_level_low", 32'(bus.db_level), 32'd0);
        run_to_two_ticks("t6_reach_wait1");
        chk("t6_in_wait1", 32'(dut.state_q), 32'(StWait1));
        r = cyc;
        rise_cnt = 0;
        step(1'b1, 1'b1);
        chk("t6_state_after_reset", 32'(dut.state_q), 32'(StZero));
        chk("t6_cnt_after_reset", 32'(dut.cnt_q), 32'd0);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        c = r + 4;
        while (c % 10 != 9) c++;
        chk("t6_rise_count", 32'(rise_cnt), 32'd1);
        chk("t6_rise_cycle", 32'(last_rise_cyc), 32'(c + 21));
        chk("t6_level_high", 32'(bus.db_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
